ram_bist: RTL and testbench
===========================

# ram_bist

Parametrised built-in self-test engine for a simple dual-port block RAM: one write port, one read port, same clock. On `start` it fills every address with a selectable data pattern, then reads every address back. Each read word is compared against the regenerated expected value. It reports pass/fail, a saturating error count, and the first failing address and data. It sits beside the RAM instance, driving its ports in place of the free-running write/read counters used so far.

## Interface
- `DW`, 16, data width in bits (≥2)
- `AW`, 9, address width; depth N = 2^AW
- `RD_LAT`, 1, RAM read latency in cycles, 1..3
- `clk`  in  1  system clock (50 MHz)
- `rst_n`  in  1  reset, asynchronous, active low
- `start`  in  1  begin a test run; sampled only in IDLE
- `pattern`  in  2  0 = address, 1 = walking one, 2 = checkerboard, 3 = inverted address; latched at start
- `busy`  out  1  high from the cycle after `start` until DONE exits
- `done`  out  1  single-cycle pulse at end of run
- `pass`  out  1  high after a run with zero errors; held until next start
- `err_cnt`  out  16  mismatch count, saturates at 16'hFFFF
- `fail_addr`  out  AW  address of first mismatch
- `fail_data`  out  DW  read data at first mismatch
- `ram_we`  out  1  RAM write enable
- `ram_waddr`  out  AW  RAM write address
- `ram_wdata`  out  DW  RAM write data
- `ram_raddr`  out  AW  RAM read address
- `ram_rdata`  in  DW  RAM read data, valid RD_LAT cycles after `ram_raddr`

## Operation
- FSM states: IDLE → WRITE → READ → DRAIN → DONE → IDLE.
- IDLE: `start`=1 latches `pattern`, clears `err_cnt`, `fail_addr`, `fail_data` and `pass`, zeroes the address counter, then enters WRITE.
- WRITE: for N cycles, `ram_we`=1, `ram_waddr` = counter 0..N-1, `ram_wdata` = pat(counter). At N-1 the counter wraps to 0 and the FSM enters READ.
- READ: for N cycles, `ram_raddr` = counter 0..N-1. The expected value and a valid flag travel through an RD_LAT-deep shift register, aligned with `ram_rdata`. At N-1 the FSM enters DRAIN.
- DRAIN: lasts RD_LAT cycles, so the last compares retire. The compare stage is active whenever the delayed valid flag is 1, in READ and DRAIN alike.
- DONE: lasts one cycle. `done`=1 and `pass` = (`err_cnt`==0). Returns to IDLE.
- pat(a), with `a` zero-extended or truncated to DW:
  - 0: `a`
  - 1: 1 << (a mod DW)
  - 2: even `a` gives {DW/2{2'b01}}, odd `a` gives {DW/2{2'b10}}
  - 3: ~`a`
- Mismatch handling:
  - `err_cnt` increments by 1 unless already 16'hFFFF.
  - If it is the first mismatch of the run, `fail_addr` and `fail_data` are captured; later mismatches never overwrite them.
- `start` while busy is ignored. `pattern` changes mid-run have no effect.
- Reset mid-run returns to IDLE immediately. RAM contents are not touched.
- Reset values: `busy`, `done`, `pass`, `ram_we` = 0; `err_cnt`, `fail_addr`, `fail_data`, `ram_waddr`, `ram_wdata`, `ram_raddr` = 0.
- When not in WRITE, `ram_we`=0 and `ram_waddr`/`ram_wdata` hold 0. When not in READ, `ram_raddr` holds 0.

## Timing
- All outputs are registered.
- `start` sampled high at edge 0:
  - write addresses issue on edges 1..N
  - read addresses issue on edges N+1..2N
  - DRAIN occupies edges 2N+1..2N+RD_LAT
  - `done` pulses on edge 2N+RD_LAT+1
  - total run = 2N+RD_LAT+1 cycles
- The read of address `a` is compared RD_LAT cycles after its issue edge.
- There is no read/write overlap, so no collision hazard exists.
- `err_cnt`, `fail_*` and `pass` are stable from the `done` edge until the next accepted `start`.

## Configuration
- `RAM_BIST_ERR_INJECT_EN` defined:
  - Adds input ports `inj_en` (1) and `inj_addr` (AW).
  - During WRITE, if `inj_en`=1 and counter==`inj_addr`, bit 0 of `ram_wdata` is inverted.
  - This gives deterministic self-check of the compare path.
- `RAM_BIST_ERR_INJECT_EN` undefined:
  - The ports are absent and write data is always pat(a).

## Test plan
Benches use DW=16, AW=4, with a behavioural RAM whose read latency matches RD_LAT.
- Reset then idle, `start`=0 → all outputs 0 for 20 cycles; `ram_we` never asserts.
- RD_LAT=1, `pattern`=0, `start` pulse → 16 writes with data 0..15, then 16 reads; `done` on cycle 34; `pass`=1; `err_cnt`=0.
- RD_LAT=3, `pattern`=1 → write data at address 5 = 16'h0020; `done` on cycle 36; `pass`=1.
- Bench RAM forces bit 3 high at address 6, `pattern`=2 → `err_cnt`=1, `fail_addr`=6, `fail_data`=16'h555D, `pass`=0.
- `RAM_BIST_ERR_INJECT_EN`, `inj_addr`=9, `pattern`=3 → `fail_addr`=9, `fail_data`=16'hFFF7, `err_cnt`=1.
- `rst_n` low during READ at address 7 → all outputs 0 next cycle. A second `start` pulse during the following run is ignored. A fresh run after reset passes with `pattern`=0.

Source files
------------

// File: rtl/ram_bist.sv
// ram_bist: fill-then-readback self-test engine for a one-write/one-read,
// same-clock block RAM. Writes pat(a) to every address, reads every address
// back, and compares each word against the regenerated pattern.
// Optional feature macro: RAM_BIST_ERR_INJECT_EN adds inj_en/inj_addr. When
// both match during WRITE, bit 0 of that one written word is flipped, which
// gives a known mismatch to exercise the compare path.
//
// state | meaning
// IDLE  | waiting for start; outputs idle, results held
// WRITE | ram_we high, writing pat(cnt) to address cnt, cnt = 0..N-1
// READ  | issuing ram_raddr = cnt, cnt = 0..N-1
// DRAIN | RD_LAT cycles so the last in-flight compares retire
// DONE  | one-cycle done pulse, pass resolved from err_cnt
module ram_bist #(
    parameter int DW     = 16,
    parameter int AW     = 9,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    pattern,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [15:0]   err_cnt,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_data,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_rdata
`ifdef RAM_BIST_ERR_INJECT_EN
    ,
    input  logic          inj_en,
    input  logic [AW-1:0] inj_addr
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [1:0] DRAIN_LD = 2'(RD_LAT - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q;
    logic [1:0]    drain_q;
    logic [1:0]    pat_q;
    logic          cnt_last;
    logic [DW-1:0] wr_flip;
    logic          cmp_err;

    logic          vld_pipe [RD_LAT];
    logic [DW-1:0] exp_pipe [RD_LAT];
    logic [AW-1:0] adr_pipe [RD_LAT];

    // Pattern generator; address is zero-extended or truncated to DW.
    function automatic logic [DW-1:0] pat_f(input logic [1:0] sel, input logic [AW-1:0] a);
        logic [DW-1:0] ae;
        logic [DW-1:0] r;
        ae = DW'(a);
        r  = '0;
        case (sel)
            2'd0: r = ae;
            2'd1: r = DW'(1) << (int'(a) % DW);
            2'd2: begin
                for (int i = 0; i < DW; i++) begin
                    r[i] = a[0] ? (i % 2 == 1) : (i % 2 == 0);
                end
            end
            default: r = ~ae;
        endcase
        return r;
    endfunction

    assign cnt_last = &cnt_q;
    assign cmp_err  = vld_pipe[RD_LAT-1] && (ram_rdata != exp_pipe[RD_LAT-1]);

    // Write-data corruption for the optional injection feature.
    always_comb begin
        wr_flip = '0;
`ifdef RAM_BIST_ERR_INJECT_EN
        if (inj_en && (cnt_q == inj_addr)) begin
            wr_flip = DW'(1);
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_WRITE;
            S_WRITE: if (cnt_last) state_d = S_READ;
            S_READ:  if (cnt_last) state_d = S_DRAIN;
            S_DRAIN: if (drain_q == 2'd0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Address counter, drain down-counter and latched pattern select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            drain_q <= '0;
            pat_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (start) pat_q <= pattern;
                end
                S_WRITE: cnt_q <= cnt_q + AW'(1);
                S_READ: begin
                    cnt_q <= cnt_q + AW'(1);
                    if (cnt_last) drain_q <= DRAIN_LD;
                end
                S_DRAIN: begin
                    cnt_q <= '0;
                    if (drain_q != 2'd0) drain_q <= drain_q - 2'd1;
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    // Expected-data / valid / address pipeline, aligned with ram_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_pipe[i] <= 1'b0;
                exp_pipe[i] <= '0;
                adr_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0] <= (state_q == S_READ);
            exp_pipe[0] <= pat_f(pat_q, cnt_q);
            adr_pipe[0] <= cnt_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                exp_pipe[i] <= exp_pipe[i-1];
                adr_pipe[i] <= adr_pipe[i-1];
            end
        end
    end

    // Registered RAM port drive, status outputs and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            ram_raddr <= '0;
        end else begin
            done      <= 1'b0;
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            ram_raddr <= '0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        err_cnt   <= '0;
                        fail_addr <= '0;
                        fail_data <= '0;
                    end
                end
                S_WRITE: begin
                    ram_we    <= 1'b1;
                    ram_waddr <= cnt_q;
                    ram_wdata <= pat_f(pat_q, cnt_q) ^ wr_flip;
                end
                S_READ: ram_raddr <= cnt_q;
                S_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    pass <= (err_cnt == 16'd0);
                end
                default: ;
            endcase
            // A zero count means no mismatch yet this run, so this is the first.
            if (cmp_err) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                if (err_cnt == 16'd0) begin
                    fail_addr <= adr_pipe[RD_LAT-1];
                    fail_data <= ram_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: two instances (read latency 1 and 3), each beside a
// behavioural RAM with a matching read latency. A write scoreboard queues the
// expected address/data for every write when start is driven and pops them as
// the DUT issues writes.
`timescale 1ns/1ps
module tb_ram_bist;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int N  = 16;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    pattern = 2'd0;
    logic          inj_en = 1'b0;
    logic [AW-1:0] inj_addr = '0;
    logic          bug_one = 1'b0;
    logic          bug_all = 1'b0;

    logic          busy1, done1, pass1, we1, busy3, done3, pass3, we3;
    logic [15:0]   err1, err3;
    logic [AW-1:0] faddr1, waddr1, raddr1, faddr3, waddr3, raddr3;
    logic [DW-1:0] fdata1, wdata1, rdata1, fdata3, wdata3, rdata3;
    logic [63:0]   outs1, outs3;

    logic [DW-1:0] mem1 [N];
    logic [DW-1:0] mem3 [N];
    logic [DW-1:0] rd3_comb, r3a, r3b;

    wr_t           q1[$];
    wr_t           q3[$];
    wr_t           e1, e3;
    logic [DW-1:0] w5_3;
    int            checks = 0;
    int            errors = 0;

    always #10 clk = ~clk;

    ram_bist #(.DW(DW), .AW(AW), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .fail_addr(faddr1), .fail_data(fdata1), .ram_we(we1),
        .ram_waddr(waddr1), .ram_wdata(wdata1), .ram_raddr(raddr1),
        .ram_rdata(rdata1)
`ifdef RAM_BIST_ERR_INJECT_EN
        , .inj_en(inj_en), .inj_addr(inj_addr)
`endif
    );

    ram_bist #(.DW(DW), .AW(AW), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern),
        .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
        .fail_addr(faddr3), .fail_data(fdata3), .ram_we(we3),
        .ram_waddr(waddr3), .ram_wdata(wdata3), .ram_raddr(raddr3),
        .ram_rdata(rdata3)
`ifdef RAM_BIST_ERR_INJECT_EN
        , .inj_en(inj_en), .inj_addr(inj_addr)
`endif
    );

    assign outs1 = {busy1, done1, pass1, err1, faddr1, fdata1, we1, waddr1, wdata1, raddr1};
    assign outs3 = {busy3, done3, pass3, err3, faddr3, fdata3, we3, waddr3, wdata3, raddr3};

    // Behavioural RAMs; bug_one/bug_all force bit 3 high on the read path.
    initial begin
        for (int i = 0; i < N; i++) begin
            mem1[i] = '0;
            mem3[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (we1) mem1[waddr1] <= wdata1;
        if (we3) mem3[waddr3] <= wdata3;
        r3a <= rd3_comb;
        r3b <= r3a;
    end

    assign rdata1   = mem1[raddr1] | (((bug_one && raddr1 == 4'd6) || bug_all) ? 16'h0008 : 16'h0000);
    assign rd3_comb = mem3[raddr3] | (((bug_one && raddr3 == 4'd6) || bug_all) ? 16'h0008 : 16'h0000);
    assign rdata3   = r3b;

    function automatic logic [DW-1:0] exp_pat(input logic [1:0] p, input logic [AW-1:0] a);
        case (p)
            2'd0: return {12'h000, a};
            2'd1: return 16'h0001 << a;
            2'd2: return a[0] ? 16'hAAAA : 16'h5555;
            default: return ~{12'h000, a};
        endcase
    endfunction

    // Write scoreboard monitors.
    always @(negedge clk) begin
        checks++;
        if (we1) begin
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL wr_sb1: unexpected write addr=%0d data=%h", waddr1, wdata1);
            end else begin
                e1 = q1.pop_front();
                if (waddr1 !== e1.a || wdata1 !== e1.d) begin
                    errors++;
                    $display("FAIL wr_sb1: got addr=%0d data=%h, expected addr=%0d data=%h", waddr1, wdata1, e1.a, e1.d);
                end
            end
        end else if (waddr1 !== '0 || wdata1 !== '0) begin
            errors++;
            $display("FAIL wr_idle1: got waddr=%0d wdata=%h, expected 0/0", waddr1, wdata1);
        end
    end

    always @(negedge clk) begin
        checks++;
        if (we3) begin
            if (waddr3 == 4'd5) w5_3 = wdata3;
            if (q3.size() == 0) begin
                errors++;
                $display("FAIL wr_sb3: unexpected write addr=%0d data=%h", waddr3, wdata3);
            end else begin
                e3 = q3.pop_front();
                if (waddr3 !== e3.a || wdata3 !== e3.d) begin
                    errors++;
                    $display("FAIL wr_sb3: got addr=%0d data=%h, expected addr=%0d data=%h", waddr3, wdata3, e3.a, e3.d);
                end
            end
        end else if (waddr3 !== '0 || wdata3 !== '0) begin
            errors++;
            $display("FAIL wr_idle3: got waddr=%0d wdata=%h, expected 0/0", waddr3, wdata3);
        end
    end

    task automatic push_expected(input logic [1:0] p);
        wr_t w;
        for (int a = 0; a < N; a++) begin
            w.a = AW'(a);
            w.d = exp_pat(p, AW'(a));
            if (inj_en && AW'(a) == inj_addr) w.d[0] = ~w.d[0];
            q1.push_back(w);
            q3.push_back(w);
        end
    endtask

    // Pulses start (edge 0) then watches 60 edges; pattern is scrambled at
    // edge 3 and start is re-pulsed at restart_at to show both are ignored.
    task automatic do_run(input logic [1:0] p, input int restart_at,
                          output int d1, output int d3, output int n1, output int n3,
                          output logic b);
        d1 = -1; d3 = -1; n1 = 0; n3 = 0;
        @(negedge clk);
        pattern = p;
        start   = 1'b1;
        push_expected(p);
        @(posedge clk);
        #1;
        start = 1'b0;
        b = busy1 & busy3;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) pattern = ~p;
            start = (k == restart_at);
            if (done1) begin
                n1++;
                if (d1 < 0) d1 = k;
            end
            if (done3) begin
                n3++;
                if (d3 < 0) d3 = k;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (outs1 !== '0 || outs3 !== '0) begin
            errors++;
            $display("FAIL reset_hold: got %h / %h, expected 0", outs1, outs3);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (outs1 !== '0 || outs3 !== '0) begin
                errors++;
                $display("FAIL idle_outs cycle %0d: got %h / %h, expected 0", k, outs1, outs3);
            end
        end
    endtask

    task automatic test_address_pattern;
        int d1, d3, n1, n3;
        logic b;
        do_run(2'd0, -1, d1, d3, n1, n3, b);
        checks++;
        if (b !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b, expected 1", b); end
        checks++;
        if (d1 !== 34) begin errors++; $display("FAIL done_cycle_lat1: got %0d, expected 34", d1); end
        checks++;
        if (d3 !== 36) begin errors++; $display("FAIL done_cycle_lat3: got %0d, expected 36", d3); end
        checks++;
        if (n1 !== 1 || n3 !== 1) begin errors++; $display("FAIL done_pulses: got %0d/%0d, expected 1/1", n1, n3); end
        checks++;
        if (pass1 !== 1'b1 || pass3 !== 1'b1) begin errors++; $display("FAIL pass_addr: got %b/%b, expected 1/1", pass1, pass3); end
        checks++;
        if (err1 !== 16'd0 || err3 !== 16'd0) begin errors++; $display("FAIL err_addr: got %0d/%0d, expected 0/0", err1, err3); end
        checks++;
        if (busy1 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL busy_end: got %b/%b, expected 0/0", busy1, busy3); end
        checks++;
        if (q1.size() != 0 || q3.size() != 0) begin errors++; $display("FAIL writes_missing: got %0d/%0d left, expected 0/0", q1.size(), q3.size()); end
    endtask

    task automatic test_walking_one;
        int d1, d3, n1, n3;
        logic b;
        w5_3 = '0;
        do_run(2'd1, -1, d1, d3, n1, n3, b);
        checks++;
        if (w5_3 !== 16'h0020) begin errors++; $display("FAIL walk_wdata5: got %h, expected 0020", w5_3); end
        checks++;
        if (d3 !== 36) begin errors++; $display("FAIL walk_done_lat3: got %0d, expected 36", d3); end
        checks++;
        if (pass1 !== 1'b1 || pass3 !== 1'b1) begin errors++; $display("FAIL walk_pass: got %b/%b, expected 1/1", pass1, pass3); end
    endtask

    task automatic test_read_bitflip;
        int d1, d3, n1, n3;
        logic b;
        bug_one = 1'b1;
        do_run(2'd2, -1, d1, d3, n1, n3, b);
        bug_one = 1'b0;
        checks++;
        if (err1 !== 16'd1 || err3 !== 16'd1) begin errors++; $display("FAIL flip_err: got %0d/%0d, expected 1/1", err1, err3); end
        checks++;
        if (faddr1 !== 4'd6 || faddr3 !== 4'd6) begin errors++; $display("FAIL flip_addr: got %0d/%0d, expected 6/6", faddr1, faddr3); end
        checks++;
        if (fdata1 !== 16'h555D || fdata3 !== 16'h555D) begin errors++; $display("FAIL flip_data: got %h/%h, expected 555d", fdata1, fdata3); end
        checks++;
        if (pass1 !== 1'b0 || pass3 !== 1'b0) begin errors++; $display("FAIL flip_pass: got %b/%b, expected 0/0", pass1, pass3); end
    endtask

    task automatic test_first_capture;
        int d1, d3, n1, n3;
        logic b;
        bug_all = 1'b1;
        do_run(2'd0, -1, d1, d3, n1, n3, b);
        bug_all = 1'b0;
        checks++;
        if (err1 !== 16'd8 || err3 !== 16'd8) begin errors++; $display("FAIL multi_err: got %0d/%0d, expected 8/8", err1, err3); end
        checks++;
        if (faddr1 !== 4'd0 || faddr3 !== 4'd0) begin errors++; $display("FAIL multi_addr: got %0d/%0d, expected 0/0", faddr1, faddr3); end
        checks++;
        if (fdata1 !== 16'h0008 || fdata3 !== 16'h0008) begin errors++; $display("FAIL multi_data: got %h/%h, expected 0008", fdata1, fdata3); end
    endtask

`ifdef RAM_BIST_ERR_INJECT_EN
    task automatic test_inject;
        int d1, d3, n1, n3;
        logic b;
        inj_en   = 1'b1;
        inj_addr = 4'd9;
        do_run(2'd3, -1, d1, d3, n1, n3, b);
        inj_en = 1'b0;
        checks++;
        if (err1 !== 16'd1 || err3 !== 16'd1) begin errors++; $display("FAIL inj_err: got %0d/%0d, expected 1/1", err1, err3); end
        checks++;
        if (faddr1 !== 4'd9 || faddr3 !== 4'd9) begin errors++; $display("FAIL inj_addr: got %0d/%0d, expected 9/9", faddr1, faddr3); end
        checks++;
        if (fdata1 !== 16'hFFF7 || fdata3 !== 16'hFFF7) begin errors++; $display("FAIL inj_data: got %h/%h, expected fff7", fdata1, fdata3); end
    endtask
`endif

    task automatic test_reset_midrun;
        logic found;
        found = 1'b0;
        @(negedge clk);
        pattern = 2'd0;
        start   = 1'b1;
        push_expected(2'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(posedge clk);
            #1;
            if (raddr1 == 4'd7 && raddr3 == 4'd7) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL reach_read7: got timeout, expected raddr 7"); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs1 !== '0 || outs3 !== '0) begin errors++; $display("FAIL midrun_reset: got %h / %h, expected 0", outs1, outs3); end
        @(posedge clk);
        #1;
        checks++;
        if (outs1 !== '0 || outs3 !== '0) begin errors++; $display("FAIL midrun_reset_next: got %h / %h, expected 0", outs1, outs3); end
        q1.delete();
        q3.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back;
        int d1, d3, n1, n3;
        logic b;
        do_run(2'd0, 10, d1, d3, n1, n3, b);
        checks++;
        if (d1 !== 34 || d3 !== 36) begin errors++; $display("FAIL restart_done: got %0d/%0d, expected 34/36", d1, d3); end
        checks++;
        if (n1 !== 1 || n3 !== 1) begin errors++; $display("FAIL restart_pulses: got %0d/%0d, expected 1/1", n1, n3); end
        checks++;
        if (pass1 !== 1'b1 || pass3 !== 1'b1 || err1 !== 16'd0 || err3 !== 16'd0) begin
            errors++;
            $display("FAIL restart_pass: got pass %b/%b err %0d/%0d, expected 1/1 0/0", pass1, pass3, err1, err3);
        end
        checks++;
        if (q1.size() != 0 || q3.size() != 0) begin errors++; $display("FAIL restart_writes: got %0d/%0d left, expected 0/0", q1.size(), q3.size()); end
    endtask

    initial begin
        test_reset();
        test_address_pattern();
        test_walking_one();
        test_read_bitflip();
        test_first_capture();
`ifdef RAM_BIST_ERR_INJECT_EN
        test_inject();
`endif
        test_reset_midrun();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
